// File: rtl/optimizer_job_scheduler_pkg.sv
// Shared types and descriptor layout for the optimizer job scheduler.
package hft_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

  // Job descriptor: [1:0] base_select, [9:2] strategy_id
  localparam int JOB_DESC_W = 10;
  localparam int BASE_LSB   = 0;
  localparam int BASE_W     = 2;
  localparam int STRAT_LSB  = 2;
  localparam int STRAT_W    = 8;
  localparam int TO_CNT_W   = 16;

endpackage

// File: rtl/optimizer_job_scheduler_arb.sv
// Combinational round-robin arbiter: grants the first requester after
// i_last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_last_grant,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_index,
  output logic               o_found
);

  logic [ID_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_index = '0;
    o_found = 1'b0;
    w_idx   = '0;
    // Scan farthest-to-nearest so the nearest valid requester wins.
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = ID_W'((int'(i_last_grant) + off) % NUM_REQ);
      if (i_req[w_idx]) begin
        o_found = 1'b1;
        o_index = w_idx;
      end
    end
    if (o_found) o_grant[o_index] = 1'b1;
  end

endmodule

// File: rtl/optimizer_job_scheduler.sv
// Shares one optimizer core between NUM_REQ requesters: round-robin accept,
// start pulse, completion/timeout wait, and a valid/ready response channel.
module optimizer_job_scheduler
  import hft_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int JOB_W          = JOB_DESC_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PROFIT_W       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sched_enable,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*JOB_W-1:0] req_job,
  output logic                     core_start,
  output logic [BASE_W-1:0]        core_base_select,
  output logic [STRAT_W-1:0]       core_strategy_id,
  input  logic                     core_complete,
  input  logic                     core_trade_valid,
  input  logic [PROFIT_W-1:0]      core_profit,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_trade_valid,
  output logic [PROFIT_W-1:0]      rsp_profit,
  output logic                     rsp_timeout,
  output logic                     busy,
  output logic [TO_CNT_W-1:0]      timeout_count
);

  localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t          r_state;
  sched_state_t          w_next_state;
  logic [ID_W-1:0]       r_last_grant;
  logic [BASE_W-1:0]     r_base;
  logic [STRAT_W-1:0]    r_strat;
  logic [ID_W-1:0]       r_rsp_id;
  logic                  r_rsp_trade;
  logic [PROFIT_W-1:0]   r_rsp_profit;
  logic                  r_rsp_timeout;
  logic [CNT_W-1:0]      r_wait_cnt;
  logic                  r_armed;
  logic [TO_CNT_W-1:0]   r_timeout_count;

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_index;
  logic                  w_found;
  logic [JOB_W-1:0]      w_job;
  logic                  w_accept;
  logic                  w_done_ok;
  logic                  w_done_to;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_arb (
    .i_req       (req_valid),
    .i_last_grant(r_last_grant),
    .o_grant     (w_grant),
    .o_index     (w_index),
    .o_found     (w_found)
  );

  always_comb begin
    w_job = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_index == ID_W'(i)) w_job = req_job[i*JOB_W +: JOB_W];
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done_ok    = 1'b0;
    w_done_to    = 1'b0;
    core_start   = 1'b0;
    req_ready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (sched_enable && w_found && !rst) begin
          req_ready    = w_grant;
          w_accept     = 1'b1;
          w_next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_start   = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion only counts once the level has been seen low this job.
        if (r_armed && core_complete) begin
          w_done_ok    = 1'b1;
          w_next_state = ST_RESP;
        end else if (r_wait_cnt == CNT_LAST) begin
          w_done_to    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_last_grant    <= ID_W'(NUM_REQ - 1);
      r_base          <= '0;
      r_strat         <= '0;
      r_rsp_id        <= '0;
      r_rsp_trade     <= 1'b0;
      r_rsp_profit    <= '0;
      r_rsp_timeout   <= 1'b0;
      r_wait_cnt      <= '0;
      r_armed         <= 1'b0;
      r_timeout_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_base       <= w_job[BASE_LSB +: BASE_W];
        r_strat      <= w_job[STRAT_LSB +: STRAT_W];
        r_rsp_id     <= w_index;
        r_last_grant <= w_index;
      end
      if (r_state == ST_ISSUE) begin
        r_wait_cnt <= '0;
        r_armed    <= 1'b0;
      end
      if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
        if (!core_complete) r_armed <= 1'b1;
      end
      if (w_done_ok) begin
        r_rsp_trade   <= core_trade_valid;
        r_rsp_profit  <= core_profit;
        r_rsp_timeout <= 1'b0;
      end
      if (w_done_to) begin
        r_rsp_trade   <= 1'b0;
        r_rsp_profit  <= '0;
        r_rsp_timeout <= 1'b1;
        if (r_timeout_count != {TO_CNT_W{1'b1}}) r_timeout_count <= r_timeout_count + 1'b1;
      end
    end
  end

  assign core_base_select = r_base;
  assign core_strategy_id = r_strat;
  assign rsp_valid        = (r_state == ST_RESP);
  assign busy             = (r_state != ST_IDLE);
  assign rsp_id           = r_rsp_id;
  assign rsp_trade_valid  = r_rsp_trade;
  assign rsp_profit       = r_rsp_profit;
  assign rsp_timeout      = r_rsp_timeout;
  assign timeout_count    = r_timeout_count;

endmodule

// File: tb/tb_optimizer_job_scheduler.sv
// Self-checking bench: job-level reference model plus directed and random scenarios.
module tb_optimizer_job_scheduler;

  localparam int N  = 4;
  localparam int IDW = 2;
  localparam int JW = 10;
  localparam int T  = 16;
  localparam int PW = 32;

  logic            clk;
  logic            rst;
  logic            sched_enable;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*JW-1:0] req_job;
  logic            core_start;
  logic [1:0]      core_base_select;
  logic [7:0]      core_strategy_id;
  logic            core_complete;
  logic            core_trade_valid;
  logic [PW-1:0]   core_profit;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_trade_valid;
  logic [PW-1:0]   rsp_profit;
  logic            rsp_timeout;
  logic            busy;
  logic [15:0]     timeout_count;

  optimizer_job_scheduler #(
    .NUM_REQ(N), .ID_W(IDW), .JOB_W(JW), .TIMEOUT_CYCLES(T), .PROFIT_W(PW)
  ) dut (
    .clk(clk), .rst(rst), .sched_enable(sched_enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_job(req_job),
    .core_start(core_start), .core_base_select(core_base_select),
    .core_strategy_id(core_strategy_id), .core_complete(core_complete),
    .core_trade_valid(core_trade_valid), .core_profit(core_profit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_trade_valid(rsp_trade_valid), .rsp_profit(rsp_profit),
    .rsp_timeout(rsp_timeout), .busy(busy), .timeout_count(timeout_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] sh;
    for (int o = 1; o <= N; o++) begin
      sh = v >> ((last + o) % N);
      if (sh[0]) return (last + o) % N;
    end
    return -1;
  endfunction

  // core stub controls (written by stimulus, read by the checker loop)
  bit          st_stale = 1'b0;
  int          st_lo = 0;
  int          st_hi = 1000;
  bit          st_trade = 1'b0;
  logic [31:0] st_profit = '0;
  bit          st_act = 1'b0;
  int          st_k = 0;

  // reference model: what the scheduler must be doing this cycle
  bit          m_init = 1'b0;
  bit          m_active, m_started, m_done, m_saw_low, m_trade, m_to;
  int          m_elapsed, m_last, m_id, m_tcount;
  logic [1:0]  m_base;
  logic [7:0]  m_strat;
  logic [31:0] m_profit;

  int          n_starts = 0;
  int          start_cyc = 0;
  int          rsp_cyc = 0;
  logic [1:0]  start_base;
  logic [7:0]  start_strat;
  bit          prev_rsp = 1'b0;
  bit          grant_open = 1'b0;
  logic [N-1:0] last_ready = '0;
  int          acc_q[$];

  initial begin
    forever begin
      int g;
      int ai;
      logic [N-1:0]  er;
      logic [JW-1:0] jj;
      @(negedge clk);
      cyc++;
      g  = (!m_active && sched_enable && !rst) ? pick(req_valid, m_last) : -1;
      er = (g >= 0) ? (N'(1) << g) : '0;
      if (m_init) begin
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(m_active));
        chk("core_start", 64'(core_start), 64'(m_active && !m_started));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_done));
        chk("core_base_select", 64'(core_base_select), 64'(m_base));
        chk("core_strategy_id", 64'(core_strategy_id), 64'(m_strat));
        chk("timeout_count", 64'(timeout_count), 64'(m_tcount));
        if (m_done) begin
          chk("rsp_id", 64'(rsp_id), 64'(m_id));
          chk("rsp_trade_valid", 64'(rsp_trade_valid), 64'(m_trade));
          chk("rsp_profit", 64'(rsp_profit), 64'(m_profit));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
        end
      end
      if (core_start) begin
        n_starts++;
        start_cyc   = cyc;
        start_base  = core_base_select;
        start_strat = core_strategy_id;
      end
      if (rsp_valid && !prev_rsp) rsp_cyc = cyc;
      prev_rsp = rsp_valid;
      if (|req_ready) begin
        ai = -1;
        for (int i = 0; i < N; i++) if (((req_ready >> i) & N'(1)) != '0) ai = i;
        acc_q.push_back(ai);
        chk("one_job_in_flight", 64'(grant_open), 64'(0));
        grant_open = 1'b1;
      end
      if ((rsp_valid && rsp_ready) || rst) grant_open = 1'b0;
      last_ready = req_ready;

      // core stub: complete level as a function of cycles since the start pulse
      if (rst) st_act = 1'b0;
      else if (core_start) begin st_act = 1'b1; st_k = 0; end
      else if (st_act) st_k++;
      core_complete    = st_act ? ((st_k < st_lo) ? st_stale : (st_k >= st_hi)) : st_stale;
      core_trade_valid = st_trade;
      core_profit      = st_profit;

      // advance model to next cycle
      if (rst) begin
        m_init = 1'b1; m_active = 0; m_started = 0; m_done = 0; m_last = N - 1;
        m_base = '0; m_strat = '0; m_id = 0; m_trade = 0; m_profit = '0; m_to = 0; m_tcount = 0;
      end else if (m_done) begin
        if (rsp_ready) begin m_done = 0; m_active = 0; end
      end else if (m_active && !m_started) begin
        m_started = 1; m_elapsed = 0; m_saw_low = 0;
      end else if (m_active) begin
        if (m_saw_low && core_complete) begin
          m_done = 1; m_trade = core_trade_valid; m_profit = core_profit; m_to = 0;
        end else if (m_elapsed == T - 1) begin
          m_done = 1; m_trade = 0; m_profit = '0; m_to = 1;
          if (m_tcount < 65535) m_tcount++;
        end
        m_elapsed++;
        if (!core_complete) m_saw_low = 1;
      end else if (g >= 0) begin
        jj = JW'(req_job >> (g * JW));
        m_active = 1; m_started = 0; m_last = g; m_id = g;
        m_base = jj[1:0]; m_strat = jj[9:2];
      end
    end
  end

  logic [N-1:0] dropped;

  task automatic step();
    @(posedge clk);
    #1;
    dropped   = req_valid & last_ready;
    req_valid = req_valid & ~last_ready;
  endtask

  task automatic set_job(input int i, input logic [JW-1:0] jv);
    req_job = (req_job & ~((N*JW)'(10'h3FF) << (i * JW))) | ((N*JW)'(jv) << (i * JW));
  endtask

  task automatic wait_rsp(input string name, input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin step(); n++; end
    chk(name, 64'(rsp_valid), 64'(1));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin step(); n++; end
    chk(name, 64'(busy), 64'(0));
  endtask

  task automatic wait_acc(input string name, input int target, input int budget);
    int n = 0;
    while (acc_q.size() < target && n < budget) begin step(); n++; end
    chk(name, 64'(acc_q.size()), 64'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, a0;
    int fexp[6];
    fexp = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; sched_enable = 1'b0; req_valid = '0; req_job = '0; rsp_ready = 1'b0;
    core_complete = 1'b0; core_trade_valid = 1'b0; core_profit = '0;
    step(); step(); step();
    rst = 1'b0;
    step();
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_core_start", 64'(core_start), 64'(0));
    chk("reset_base", 64'(core_base_select), 64'(0));
    chk("reset_strat", 64'(core_strategy_id), 64'(0));
    chk("reset_timeout_count", 64'(timeout_count), 64'(0));

    // single job
    st_stale = 0; st_lo = 0; st_hi = 6; st_trade = 1; st_profit = 32'd1000;
    sched_enable = 1; rsp_ready = 1;
    set_job(0, {8'd5, 2'd2});
    s0 = n_starts;
    req_valid = 4'b0001;
    wait_rsp("single_rsp_seen", 50);
    chk("single_rsp_id", 64'(rsp_id), 64'(0));
    chk("single_trade", 64'(rsp_trade_valid), 64'(1));
    chk("single_profit", 64'(rsp_profit), 64'(1000));
    chk("single_timeout", 64'(rsp_timeout), 64'(0));
    wait_idle("single_idle", 20);
    chk("single_starts", 64'(n_starts - s0), 64'(1));
    chk("single_start_base", 64'(start_base), 64'(2));
    chk("single_start_strat", 64'(start_strat), 64'(5));
    chk("single_latency", 64'(rsp_cyc - start_cyc), 64'(7));

    // fairness from a fresh reset
    do_reset();
    st_hi = 3;
    for (int i = 0; i < N; i++) set_job(i, JW'($urandom));
    a0 = acc_q.size();
    req_valid = 4'hF;
    begin
      int n = 0;
      while (acc_q.size() < a0 + 6 && n < 300) begin
        step();
        req_valid = req_valid | (4'hF & ~dropped);
        n++;
      end
    end
    req_valid = '0;
    chk("fair_accepts", 64'(acc_q.size() - a0), 64'(6));
    for (int k = 0; k < 6; k++) chk("fair_order", 64'(acc_q[a0 + k]), 64'(fexp[k]));
    wait_idle("fair_idle", 40);

    // timeout
    st_hi = 1000; st_trade = 1; st_profit = 32'd555;
    set_job(1, {8'h33, 2'd1});
    req_valid = 4'b0010;
    wait_rsp("to_rsp_seen", 60);
    chk("to_flag", 64'(rsp_timeout), 64'(1));
    chk("to_profit", 64'(rsp_profit), 64'(0));
    chk("to_trade", 64'(rsp_trade_valid), 64'(0));
    chk("to_count", 64'(timeout_count), 64'(1));
    wait_idle("to_idle", 20);
    chk("to_latency", 64'(rsp_cyc - start_cyc), 64'(17));

    // stale completion level
    st_stale = 1; st_lo = 2; st_hi = 5; st_trade = 0; st_profit = 32'd77;
    set_job(0, {8'h12, 2'd0});
    req_valid = 4'b0001;
    wait_rsp("stale_rsp_seen", 40);
    chk("stale_profit", 64'(rsp_profit), 64'(77));
    chk("stale_timeout", 64'(rsp_timeout), 64'(0));
    wait_idle("stale_idle", 20);
    chk("stale_latency", 64'(rsp_cyc - start_cyc), 64'(6));

    // backpressure
    st_stale = 0; st_lo = 0; st_hi = 3; st_trade = 1; st_profit = 32'hABCD;
    rsp_ready = 0;
    set_job(3, {8'h44, 2'd3});
    req_valid = 4'b1000;
    wait_rsp("bp_rsp_seen", 40);
    a0 = acc_q.size();
    set_job(1, {8'h55, 2'd1});
    req_valid = req_valid | 4'b0010;
    st_profit = 32'h1111;
    repeat (10) begin
      step();
      chk("bp_valid_held", 64'(rsp_valid), 64'(1));
      chk("bp_profit_held", 64'(rsp_profit), 64'(32'hABCD));
      chk("bp_id_held", 64'(rsp_id), 64'(3));
      chk("bp_no_grant", 64'(req_ready), 64'(0));
    end
    chk("bp_no_accept", 64'(acc_q.size()), 64'(a0));
    rsp_ready = 1;
    wait_acc("bp_next_accept", a0 + 1, 20);
    chk("bp_next_id", 64'(acc_q[acc_q.size() - 1]), 64'(1));
    wait_idle("bp_idle", 40);

    // reset in the middle of WAIT
    st_hi = 1000;
    set_job(2, {8'hA5, 2'd3});
    s0 = n_starts;
    req_valid = 4'b0100;
    begin
      int n = 0;
      while (n_starts == s0 && n < 20) begin step(); n++; end
    end
    chk("mid_started", 64'(n_starts - s0), 64'(1));
    step(); step(); step();
    chk("mid_in_wait", 64'(busy), 64'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("mid_base", 64'(core_base_select), 64'(0));
    chk("mid_strat", 64'(core_strategy_id), 64'(0));
    chk("mid_rsp_profit", 64'(rsp_profit), 64'(0));
    chk("mid_rsp_timeout", 64'(rsp_timeout), 64'(0));
    chk("mid_timeout_count", 64'(timeout_count), 64'(0));
    a0 = acc_q.size();
    req_valid = 4'hF;
    wait_acc("mid_next_accept", a0 + 1, 20);
    chk("mid_next_id", 64'(acc_q[a0]), 64'(0));
    req_valid = '0;
    wait_idle("mid_idle", 60);

    // random traffic against the model
    a0 = acc_q.size();
    for (int c = 0; c < 2000; c++) begin
      step();
      rsp_ready    = ($urandom_range(0, 3) != 0);
      sched_enable = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++) begin
        if ((((req_valid | dropped) >> i) & N'(1)) == '0 && $urandom_range(0, 5) == 0) begin
          set_job(i, JW'($urandom));
          req_valid = req_valid | (N'(1) << i);
        end
      end
      if (!busy) begin
        st_stale  = $urandom_range(0, 1) != 0;
        st_lo     = $urandom_range(0, 4);
        st_hi     = ($urandom_range(0, 3) == 0) ? 1000 : $urandom_range(1, 20);
        st_trade  = $urandom_range(0, 1) != 0;
        st_profit = $urandom;
      end
    end
    req_valid = '0;
    rsp_ready = 1;
    wait_idle("rand_idle", 60);
    chk("rand_enough_jobs", 64'(acc_q.size() - a0 > 20), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
